// File: rtl/space_pkg.sv
// Shared constants and encodings for the space-invaders blocks.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   state_e             : formation state (PLAY / CLEARED / INVADED)
//   dir_e               : horizontal march direction
package space_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_CLEARED  = 2'd1,
    ST_INVADED  = 2'd2
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/enemy_hit_detect.sv
// Combinational box-vs-circle overlap test for a single enemy.
// The circle is approximated by its bounding square, and every bound is
// written as an addition so that nothing can underflow near the screen edge.
//   alive      : enemy is present (a dead enemy never reports a hit)
//   ex, ey     : enemy top-left corner
//   bx, by, r  : bullet centre and radius
//   hit        : bullet square overlaps the enemy box
// W must leave headroom above the coordinate width so the sums cannot wrap.
module enemy_hit_detect #(
  parameter int W       = 14,
  parameter int ENEMY_W = 32,
  parameter int ENEMY_H = 24
) (
  input  logic         alive,
  input  logic [W-1:0] ex,
  input  logic [W-1:0] ey,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] r,
  output logic         hit
);

  assign hit = alive
             && (bx + r >= ex)
             && (bx <= ex + W'(ENEMY_W - 1) + r)
             && (by + r >= ey)
             && (by <= ey + W'(ENEMY_H - 1) + r);

endmodule

// File: rtl/enemy_wave.sv
// Row of N_ENEMIES invaders marching as one formation.
//   CLOCK_50, reset          : clock, synchronous active-high reset
//   pausa                    : freezes every counter and register, pulses forced low
//   bullet_valid, x/y/raio_bola_aliada : allied bullet in flight
//   x_base, y_base           : formation top-left; enemy i at x_base + i*SPACING
//   alive                    : per-enemy alive mask
//   bullet_consume           : one-cycle pulse, the allied bullet struck an enemy
//   fire_valid, fire_x/y     : one-cycle enemy shot request and its spawn point
//   score, wave, invaded     : kills (saturating), wave number (saturating), game lost
//   fsm_state                : current formation state, for observation
// Handshakes: bullet_consume and fire_valid are single-cycle strobes with no
// ready; the consumer must act in the cycle they are high. bullet_valid is a
// level that the entities block drops after seeing bullet_consume.
module enemy_wave
  import space_pkg::*;
#(
  parameter int N_ENEMIES   = 8,
  parameter int COORD_W     = 10,
  parameter int ENEMY_W     = 32,
  parameter int ENEMY_H     = 24,
  parameter int SPACING     = 48,
  parameter int X_START     = 64,
  parameter int Y_START     = 40,
  parameter int X_MAX       = 639,
  parameter int DROP_PX     = 16,
  parameter int Y_LOSE      = 400,
  parameter int TICK_DIV    = 833333,
  parameter int STEP_INIT   = 1,
  parameter int STEP_MAX    = 6,
  parameter int FIRE_TICKS  = 45,
  parameter int CLEAR_TICKS = 120,
  parameter int SCORE_W     = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pausa,
  input  logic                 bullet_valid,
  input  logic [COORD_W-1:0]   x_bola_aliada,
  input  logic [COORD_W-1:0]   y_bola_aliada,
  input  logic [COORD_W-1:0]   raio_bola_aliada,
  output logic [COORD_W-1:0]   x_base,
  output logic [COORD_W-1:0]   y_base,
  output logic [N_ENEMIES-1:0] alive,
  output logic                 bullet_consume,
  output logic                 fire_valid,
  output logic [COORD_W-1:0]   fire_x,
  output logic [COORD_W-1:0]   fire_y,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           wave,
  output logic                 invaded,
  output logic [1:0]           fsm_state
);

  localparam int AW = COORD_W + 4;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int FW = $clog2(FIRE_TICKS + 1);
  localparam int CW = $clog2(CLEAR_TICKS + 1);
  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int IW = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;

  state_e              state, next_state;
  dir_e                dir;
  logic [SW-1:0]       step;
  logic [TW-1:0]       tick_cnt;
  logic [FW-1:0]       fire_cnt;
  logic [CW-1:0]       clear_cnt;
  logic [IW-1:0]       ptr;

  logic                tick;
  logic                lose;
  logic [AW-1:0]       ex [N_ENEMIES];
  logic [N_ENEMIES-1:0] hits;
  logic                hit_any;
  logic [IW-1:0]       hit_idx;
  logic [IW-1:0]       lo, hi;
  logic                fire_found;
  logic [IW-1:0]       fire_sel;
  logic                bounce_right, bounce_left;
  logic                clear_done;

  assign tick       = !pausa && (tick_cnt == TW'(TICK_DIV - 1));
  assign lose       = (AW'(y_base) + AW'(ENEMY_H)) >= AW'(Y_LOSE);
  assign clear_done = tick && (clear_cnt == CW'(CLEAR_TICKS - 1));
  assign invaded    = (state == ST_INVADED);
  assign fsm_state  = state;

  for (genvar g = 0; g < N_ENEMIES; g++) begin : g_enemy
    assign ex[g] = AW'(x_base) + AW'(g * SPACING);
    enemy_hit_detect #(.W(AW), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H)) u_hit (
      .alive (alive[g]),
      .ex    (ex[g]),
      .ey    (AW'(y_base)),
      .bx    (AW'(x_bola_aliada)),
      .by    (AW'(y_bola_aliada)),
      .r     (AW'(raio_bola_aliada)),
      .hit   (hits[g])
    );
  end

  // Lowest-index hit, formation extents, and round-robin shooter choice.
  // Loops run from the far end so the last assignment is the winner.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    lo         = '0;
    hi         = '0;
    fire_found = 1'b0;
    fire_sel   = ptr;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (alive[i]) lo = IW'(i);
    end
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (alive[i]) hi = IW'(i);
    end
    // k = N wraps back to ptr itself, so a lone survivor keeps firing.
    for (int k = N_ENEMIES; k >= 1; k--) begin
      if (alive[(int'(ptr) + k) % N_ENEMIES]) begin
        fire_found = 1'b1;
        fire_sel   = IW'((int'(ptr) + k) % N_ENEMIES);
      end
    end
  end

  assign bounce_right = (AW'(x_base) + AW'(hi) * AW'(SPACING) + AW'(ENEMY_W - 1) + AW'(step))
                        > AW'(X_MAX);
  assign bounce_left  = (AW'(x_base) + AW'(lo) * AW'(SPACING)) < AW'(step);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_PLAY;
    else       state <= next_state;
  end

  // Invasion is checked before the cleared condition so a row that reaches
  // the bottom on its last kill still ends the game.
  always_comb begin
    next_state = state;
    if (!pausa) begin
      case (state)
        ST_PLAY: begin
          if (lose)               next_state = ST_INVADED;
          else if (alive == '0)   next_state = ST_CLEARED;
        end
        ST_CLEARED: if (clear_done) next_state = ST_PLAY;
        default:    next_state = state;
      endcase
    end
  end

  // ptr resets to the last enemy so the first shot comes from enemy 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_base         <= COORD_W'(X_START);
      y_base         <= COORD_W'(Y_START);
      alive          <= '1;
      dir            <= DIR_RIGHT;
      step           <= SW'(STEP_INIT);
      score          <= '0;
      wave           <= '0;
      tick_cnt       <= '0;
      fire_cnt       <= '0;
      clear_cnt      <= '0;
      ptr            <= IW'(N_ENEMIES - 1);
      bullet_consume <= 1'b0;
      fire_valid     <= 1'b0;
      fire_x         <= '0;
      fire_y         <= '0;
    end else if (pausa) begin
      bullet_consume <= 1'b0;
      fire_valid     <= 1'b0;
    end else begin
      bullet_consume <= 1'b0;
      fire_valid     <= 1'b0;
      tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;

      if (state == ST_PLAY && !lose) begin
        // bullet_consume high means the bullet is already spent this cycle.
        if (bullet_valid && !bullet_consume && hit_any) begin
          alive[hit_idx] <= 1'b0;
          bullet_consume <= 1'b1;
          if (score != '1) score <= score + 1'b1;
        end
        if (tick && alive != '0) begin
          if (dir == DIR_RIGHT) begin
            if (bounce_right) begin
              dir    <= DIR_LEFT;
              y_base <= y_base + COORD_W'(DROP_PX);
            end else begin
              x_base <= x_base + COORD_W'(step);
            end
          end else begin
            if (bounce_left) begin
              dir    <= DIR_RIGHT;
              y_base <= y_base + COORD_W'(DROP_PX);
            end else begin
              x_base <= x_base - COORD_W'(step);
            end
          end
        end
        if (tick) begin
          if (fire_cnt == FW'(FIRE_TICKS - 1)) begin
            fire_cnt <= '0;
            if (fire_found) begin
              fire_valid <= 1'b1;
              fire_x     <= ex[fire_sel][COORD_W-1:0] + COORD_W'(ENEMY_W / 2);
              fire_y     <= y_base + COORD_W'(ENEMY_H);
              ptr        <= fire_sel;
            end
          end else begin
            fire_cnt <= fire_cnt + 1'b1;
          end
        end
      end else if (state == ST_CLEARED && tick) begin
        if (clear_done) begin
          clear_cnt <= '0;
          alive     <= '1;
          x_base    <= COORD_W'(X_START);
          y_base    <= COORD_W'(Y_START);
          dir       <= DIR_RIGHT;
          if (wave != 4'hF) wave <= wave + 1'b1;
          if (step < SW'(STEP_MAX)) step <= step + 1'b1;
        end else begin
          clear_cnt <= clear_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_wave.sv
// Directed bench for enemy_wave with a fast tick (TICK_DIV=4, FIRE_TICKS=3,
// CLEAR_TICKS=2). Expected values are hand-derived from the marching rules.
module tb_enemy_wave;
  import space_pkg::*;

  localparam int N  = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          pausa;
  logic          bullet_valid;
  logic [CW-1:0] bx, by, br;
  logic [CW-1:0] x_base, y_base;
  logic [N-1:0]  alive;
  logic          bullet_consume;
  logic          fire_valid;
  logic [CW-1:0] fire_x, fire_y;
  logic [15:0]   score;
  logic [3:0]    wave;
  logic          invaded;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  enemy_wave #(.TICK_DIV(4), .FIRE_TICKS(3), .CLEAR_TICKS(2)) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .pausa            (pausa),
    .bullet_valid     (bullet_valid),
    .x_bola_aliada    (bx),
    .y_bola_aliada    (by),
    .raio_bola_aliada (br),
    .x_base           (x_base),
    .y_base           (y_base),
    .alive            (alive),
    .bullet_consume   (bullet_consume),
    .fire_valid       (fire_valid),
    .fire_x           (fire_x),
    .fire_y           (fire_y),
    .score            (score),
    .wave             (wave),
    .invaded          (invaded),
    .fsm_state        (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: aim the bullet at the centre of enemy idx at the current position
  task automatic aim_at(input int idx);
    bx = x_base + CW'(idx * 48 + 16);
    by = y_base + CW'(12);
    br = CW'(2);
    bullet_valid = 1'b1;
  endtask

  initial begin
    int kill_list[6];
    logic [N-1:0] exp_alive;
    int n_fire, n_cons;
    kill_list = '{0, 2, 4, 5, 6, 7};

    reset = 1'b1; pausa = 1'b0; bullet_valid = 1'b0;
    bx = '0; by = '0; br = '0;
    step_clk(2);
    check("rst_x", x_base, 64);
    check("rst_y", y_base, 40);
    check("rst_alive", alive, 8'hFF);
    check("rst_score", score, 0);
    check("rst_wave", wave, 0);
    check("rst_invaded", invaded, 0);
    check("rst_pulses", {fire_valid, bullet_consume}, 0);
    check("rst_state", fsm_state, ST_PLAY);
    reset = 1'b0;

    // third tick fires from enemy 0 using the pre-move x_base 66
    step_clk(12);
    check("fire0_valid", fire_valid, 1);
    check("fire0_x", fire_x, 82);
    check("fire0_y", fire_y, 64);
    check("tick3_x", x_base, 67);
    step_clk(1);
    check("fire0_pulse_end", fire_valid, 0);
    step_clk(3);
    check("tick4_x", x_base, 68);
    check("tick4_y", y_base, 40);
    check("tick4_alive", alive, 8'hFF);

    // single hit on enemy 1
    bx = x_base + CW'(64); by = CW'(50); br = CW'(2); bullet_valid = 1'b1;
    step_clk(1);
    check("hit1_consume", bullet_consume, 1);
    check("hit1_alive", alive, 8'hFD);
    check("hit1_score", score, 1);
    bullet_valid = 1'b0;
    step_clk(1);
    check("hit1_consume_end", bullet_consume, 0);

    // bullet straddling enemies 3 and 4: only 3 dies
    bx = x_base + CW'(3 * 48 + 32 + 4); by = CW'(50); br = CW'(12); bullet_valid = 1'b1;
    step_clk(1);
    check("hit34_consume", bullet_consume, 1);
    check("hit34_alive", alive, 8'hF5);
    check("hit34_score", score, 2);
    bullet_valid = 1'b0;
    step_clk(1);
    check("hit34_one_consume", bullet_consume, 0);
    check("tick5_x", x_base, 69);

    // pause freezes everything, then resumes on the same phase
    pausa = 1'b1;
    step_clk(20);
    check("pause_x", x_base, 69);
    check("pause_fire", fire_valid, 0);
    pausa = 1'b0;
    step_clk(4);
    check("resume_x", x_base, 70);
    check("fire1_valid", fire_valid, 1);
    check("fire1_x", fire_x, 181);

    // march to the right wall
    step_clk(4 * 202);
    check("wall_x", x_base, 272);
    check("wall_y", y_base, 40);
    step_clk(4);
    check("bounce_x", x_base, 272);
    check("bounce_y", y_base, 56);
    step_clk(4);
    check("left_x", x_base, 271);

    // kill the rest of the row
    exp_alive = 8'hF5;
    foreach (kill_list[k]) begin
      exp_alive[kill_list[k]] = 1'b0;
      exp_q.push_back(exp_alive);
    end
    foreach (kill_list[k]) begin
      aim_at(kill_list[k]);
      step_clk(1);
      check("kill_consume", bullet_consume, 1);
      check("kill_alive", alive, exp_q.pop_front());
      bullet_valid = 1'b0;
      step_clk(1);
    end
    check("cleared_state", fsm_state, ST_CLEARED);
    check("cleared_score", score, 8);

    for (int i = 0; i < 16 && wave != 4'd1; i++) step_clk(1);
    check("reload_wave", wave, 1);
    check("reload_alive", alive, 8'hFF);
    check("reload_x", x_base, 64);
    check("reload_y", y_base, 40);
    check("reload_state", fsm_state, ST_PLAY);
    step_clk(4);
    check("wave1_step2_x", x_base, 66);

    // march until the row reaches the bottom
    for (int i = 0; i < 20000 && !invaded; i++) step_clk(1);
    check("invaded", invaded, 1);
    check("invaded_y", y_base, 376);
    check("invaded_state", fsm_state, ST_INVADED);

    // nothing happens any more
    aim_at(0);
    n_fire = 0; n_cons = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk(1);
      if (fire_valid) n_fire++;
      if (bullet_consume) n_cons++;
    end
    bullet_valid = 1'b0;
    check("inv_no_fire", n_fire, 0);
    check("inv_no_consume", n_cons, 0);
    check("inv_alive", alive, 8'hFF);
    check("inv_y", y_base, 376);
    check("inv_score", score, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
